// File: rtl/perf_pkg.sv
// perf_pkg: shared constants and read-select mapping for the performance monitor bank
package perf_pkg;
  localparam int EV_INSTRET = 0;
  localparam int EV_BR_PRED = 1;
  localparam int EV_BR_MISP = 2;
  localparam int EV_STALL = 3;
  localparam logic [31:0] FINI_CODE_DEF = 32'h0002_0000;
  localparam int MMIO_CON_BIT = 31;
  function automatic int sel_of(input int core, input int evt, input int nevt);
    return 1 + core * nevt + evt;
  endfunction
endpackage

// File: rtl/cons_rr_arbiter.sv
// cons_rr_arbiter: round-robin one-hot grant; search starts at the requester after the last grant
module cons_rr_arbiter #(
  parameter int N = 4,
  localparam int CW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_acc,
  output logic [N-1:0]  o_gnt,
  output logic [CW-1:0] o_idx
);
  logic [CW-1:0] r_ptr;
  // descending scan so the nearest requester after the pointer wins
  always_comb begin
    o_idx = '0;
    for (int k = N; k >= 1; k--)
      if (i_req[(int'(r_ptr) + k) % N]) o_idx = CW'((int'(r_ptr) + k) % N);
    o_gnt = |i_req ? N'(1) << o_idx : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= CW'(N - 1);
    else if (i_acc && |i_req) r_ptr <= o_idx;
endmodule

// File: rtl/perf_monitor_bank.sv
// perf_monitor_bank: per-core event counters, halt/finish detection and an arbitrated console stream
module perf_monitor_bank import perf_pkg::*; #(
  parameter int NCORES = 4,
  parameter int NEVT = 4,
  parameter int CNT_W = 64,
  parameter int FINI_ALL = 0,
  parameter logic [31:0] FINI_CODE = FINI_CODE_DEF,
  localparam int CW = NCORES > 1 ? $clog2(NCORES) : 1,
  localparam int AW = $clog2(1 + NCORES * NEVT) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [NCORES*NEVT-1:0] evt_i,
  input  logic [NCORES-1:0]      stall_i,
  input  logic [NCORES-1:0]      mmio_wvalid_i,
  input  logic [NCORES*32-1:0]   mmio_addr_i,
  input  logic [NCORES*32-1:0]   mmio_wdata_i,
  output logic                   cons_valid_o,
  input  logic                   cons_ready_i,
  output logic [7:0]             cons_data_o,
  output logic [CW-1:0]          cons_core_o,
  output logic [NCORES-1:0]      cons_ovf_o,
  output logic [NCORES-1:0]      halted_o,
  output logic                   fini_o,
  input  logic                   rd_en_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic                   rd_valid_o,
  output logic [31:0]            rd_data_o
);
  localparam int NC = NCORES * NEVT;
  logic [CNT_W-1:0] r_mcycle, w_sel_val;
  logic [NC-1:0][CNT_W-1:0] r_cnt;
  logic [CNT_W-33:0] r_shadow;
  logic [NCORES-1:0] r_halted, r_bvld, r_ovf, w_mmio, w_fwr, w_cwr, w_gnt, w_drain;
  logic [NCORES-1:0][7:0] r_bdat;
  logic [7:0] r_cdat;
  logic [CW-1:0] r_ccore, w_gidx;
  logic [31:0] r_rd_data;
  logic [AW-2:0] w_s;
  logic r_fini, r_cvld, r_rd_valid, w_sel_ok, w_run, w_load, w_unused;
  assign w_run = en_i && !r_fini;
  assign w_load = !r_cvld || cons_ready_i;
  assign w_drain = w_load ? w_gnt : '0;
  assign w_s = rd_addr_i[AW-1:1];
  assign w_unused = ^mmio_addr_i;
  always_comb begin
    w_mmio = '0;
    w_fwr = '0;
    w_cwr = '0;
    for (int i = 0; i < NCORES; i++) begin
      w_mmio[i] = mmio_wvalid_i[i] && mmio_addr_i[i*32 + MMIO_CON_BIT] && !r_halted[i];
      w_fwr[i] = w_mmio[i] && mmio_wdata_i[i*32 +: 32] == FINI_CODE;
      w_cwr[i] = w_mmio[i] && !w_fwr[i] && !r_fini;
    end
  end
  always_comb begin
    w_sel_val = w_s == '0 ? r_mcycle : '0;
    w_sel_ok = w_s == '0;
    for (int i = 0; i < NCORES; i++)
      for (int e = 0; e < NEVT; e++)
        if (int'(w_s) == sel_of(i, e, NEVT)) begin
          w_sel_val = r_cnt[i*NEVT+e];
          w_sel_ok = 1'b1;
        end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_mcycle <= '0;
      r_cnt <= '0;
    end else if (clr_i) begin
      r_mcycle <= '0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_mcycle <= r_mcycle + CNT_W'(1);
      for (int i = 0; i < NCORES; i++)
        for (int e = 0; e < NEVT; e++)
          if (!r_halted[i] && !stall_i[i] && evt_i[i*NEVT+e]) r_cnt[i*NEVT+e] <= r_cnt[i*NEVT+e] + CNT_W'(1);
    end
  // fini samples the registered halt vector, so it trails halted_o by one cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_halted <= '0;
      r_fini <= 1'b0;
      r_ovf <= '0;
    end else if (clr_i) begin
      r_halted <= '0;
      r_fini <= 1'b0;
      r_ovf <= '0;
    end else begin
      r_halted <= r_halted | w_fwr;
      r_fini <= r_fini | ((FINI_ALL != 0) ? &r_halted : |r_halted);
      r_ovf <= r_ovf | (w_cwr & r_bvld & ~w_drain);
    end
  cons_rr_arbiter #(.N(NCORES)) u_arb (
    .clk(clk_i), .rst(rst_i), .i_req(r_bvld), .i_acc(w_load), .o_gnt(w_gnt), .o_idx(w_gidx)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_bvld <= '0;
      r_bdat <= '0;
      r_cvld <= 1'b0;
      r_cdat <= '0;
      r_ccore <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        if (w_cwr[i] && (!r_bvld[i] || w_drain[i])) begin
          r_bvld[i] <= 1'b1;
          r_bdat[i] <= mmio_wdata_i[i*32 +: 8];
        end else if (w_drain[i]) r_bvld[i] <= 1'b0;
      if (w_load) begin
        r_cvld <= |r_bvld;
        if (|r_bvld) begin
          r_cdat <= r_bdat[w_gidx];
          r_ccore <= w_gidx;
        end
      end
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
      r_shadow <= '0;
    end else begin
      r_rd_valid <= rd_en_i;
      r_rd_data <= (!rd_en_i || !w_sel_ok) ? '0 : rd_addr_i[0] ? 32'(r_shadow) : w_sel_val[31:0];
      if (clr_i) r_shadow <= '0;
      else if (rd_en_i && !rd_addr_i[0] && w_sel_ok) r_shadow <= w_sel_val[CNT_W-1:32];
    end
  assign cons_valid_o = r_cvld;
  assign cons_data_o = r_cdat;
  assign cons_core_o = r_ccore;
  assign cons_ovf_o = r_ovf;
  assign halted_o = r_halted;
  assign fini_o = r_fini;
  assign rd_valid_o = r_rd_valid;
  assign rd_data_o = r_rd_data;
endmodule

// File: tb/tb_perf_monitor_bank.sv
// tb_perf_monitor_bank: vector table, directed corner sequences and randomized run against a spec-level model
module tb_perf_monitor_bank;
  localparam logic [31:0] FC = 32'h0002_0000;
  logic clk = 0, rst = 0, en = 0, clr = 0, rdy = 0, rd_en = 0;
  logic [15:0] evt = 0;
  logic [3:0] stall = 0, wv = 0;
  logic [127:0] addr = 0, wdata = 0;
  logic [5:0] rd_addr = 0;
  logic cv, fini, rv, b_cv, b_fini, b_rv;
  logic [7:0] cd, b_cd;
  logic [1:0] cc, b_cc;
  logic [3:0] ovf, halted, b_ovf, b_halted;
  logic [31:0] rdata, b_rdata;
  int n_tot = 0, n_bad = 0;
  logic [63:0] m_cyc, m_cnt [16];
  logic [31:0] m_sh, m_rd;
  logic [3:0] m_halt;
  logic m_fini, m_rv;
  logic [9:0] q [$];
  typedef struct packed {
    logic en; logic [15:0] evt; logic [3:0] stall; logic rd; logic [4:0] s; logic h; logic [31:0] exp;
  } vec_t;
  vec_t tv [10];

  perf_monitor_bank dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .evt_i(evt), .stall_i(stall),
    .mmio_wvalid_i(wv), .mmio_addr_i(addr), .mmio_wdata_i(wdata),
    .cons_valid_o(cv), .cons_ready_i(rdy), .cons_data_o(cd), .cons_core_o(cc), .cons_ovf_o(ovf),
    .halted_o(halted), .fini_o(fini), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_valid_o(rv), .rd_data_o(rdata)
  );
  perf_monitor_bank #(.FINI_ALL(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .evt_i(evt), .stall_i(stall),
    .mmio_wvalid_i(wv), .mmio_addr_i(addr), .mmio_wdata_i(wdata),
    .cons_valid_o(b_cv), .cons_ready_i(rdy), .cons_data_o(b_cd), .cons_core_o(b_cc), .cons_ovf_o(b_ovf),
    .halted_o(b_halted), .fini_o(b_fini), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_valid_o(b_rv), .rd_data_o(b_rdata)
  );

  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1);
  end
  always @(posedge clk) if (cv && rdy) q.push_back({cc, cd});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    evt = 0; stall = 0; wv = 0; addr = 0; wdata = 0; rd_en = 0; clr = 0;
  endtask

  task automatic mw(input int c, input logic [31:0] d);
    wv[c] = 1'b1;
    addr[c*32 +: 32] = 32'h8000_0000;
    wdata[c*32 +: 32] = d;
  endtask

  task automatic rd(input int s, input logic h);
    rd_en = 1'b1;
    rd_addr = {5'(s), h};
  endtask

  task automatic model_clear();
    m_cyc = 0; m_sh = 0; m_halt = 0; m_fini = 0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
  endtask

  // one clock: advance the model from the inputs seen at the edge, then compare
  task automatic tick();
    logic [63:0] v;
    logic ok;
    logic [4:0] s;
    logic [3:0] nh;
    logic nf;
    @(posedge clk);
    s = rd_addr[5:1];
    ok = s <= 16;
    v = 0;
    if (s == 0) v = m_cyc;
    else if (ok) v = m_cnt[s - 1];
    m_rv = rd_en;
    m_rd = (!rd_en || !ok) ? 32'd0 : (rd_addr[0] ? m_sh : v[31:0]);
    if (rd_en && ok && !rd_addr[0]) m_sh = v[63:32];
    nh = m_halt;
    for (int i = 0; i < 4; i++)
      if (wv[i] && addr[i*32+31] && !m_halt[i] && wdata[i*32 +: 32] == FC) nh[i] = 1'b1;
    nf = m_fini || (m_halt != 0);
    if (en && !m_fini) begin
      m_cyc++;
      for (int i = 0; i < 4; i++)
        for (int e = 0; e < 4; e++)
          if (!m_halt[i] && !stall[i] && evt[i*4+e]) m_cnt[i*4+e]++;
    end
    m_halt = nh;
    m_fini = nf;
    if (clr) model_clear();
    #1;
    chk("rd_valid", 64'(rv), 64'(m_rv));
    chk("rd_data", 64'(rdata), 64'(m_rd));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("fini", 64'(fini), 64'(m_fini));
  endtask

  task automatic do_reset();
    idle();
    en = 0;
    rst = 1;
    #1;
    chk("rst_cons_valid", 64'(cv), 0);
    chk("rst_outs", {cd, 2'(cc), ovf, halted, fini, rv, rdata}, 0);
    model_clear();
    m_rv = 0;
    m_rd = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    tv[0] = '{1'b1, 16'h0010, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0};
    tv[1] = '{1'b1, 16'h0010, 4'h2, 1'b0, 5'd0, 1'b0, 32'd0};
    tv[2] = '{1'b1, 16'h0010, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0};
    tv[3] = '{1'b0, 16'h0000, 4'h0, 1'b1, 5'd5, 1'b0, 32'd2};
    tv[4] = '{1'b0, 16'h0000, 4'h0, 1'b1, 5'd0, 1'b0, 32'd3};
    tv[5] = '{1'b0, 16'h0000, 4'h0, 1'b1, 5'd0, 1'b1, 32'd0};
    tv[6] = '{1'b1, 16'h0800, 4'h0, 1'b1, 5'd12, 1'b0, 32'd0};
    tv[7] = '{1'b0, 16'h0000, 4'h0, 1'b1, 5'd12, 1'b0, 32'd1};
    tv[8] = '{1'b0, 16'h0000, 4'h0, 1'b1, 5'd17, 1'b0, 32'd0};
    tv[9] = '{1'b0, 16'h0000, 4'h0, 1'b1, 5'd31, 1'b1, 32'd0};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      en = tv[k].en; evt = tv[k].evt; stall = tv[k].stall;
      rd_en = tv[k].rd; rd_addr = {tv[k].s, tv[k].h};
      tick();
      if (tv[k].rd) chk($sformatf("vec%0d", k), 64'(rdata), 64'(tv[k].exp));
      idle();
    end

    // console bytes, hold under backpressure, then halt and finish
    do_reset();
    en = 1; rdy = 0; q.delete();
    mw(0, 32'h41); tick(); idle();
    chk("a_valid_n1", 64'(cv), 0);
    mw(0, 32'h42); tick(); idle();
    chk("a_byte0", {cv, cc, cd}, {1'b1, 2'd0, 8'h41});
    mw(0, FC); tick(); idle();
    chk("a_hold", {cv, cc, cd}, {1'b1, 2'd0, 8'h41});
    chk("a_halted", 64'(halted), 64'h1);
    chk("a_fini_n1", 64'(fini), 0);
    tick();
    chk("a_fini_n2", 64'(fini), 1);
    evt = 16'hffff; mw(1, 32'h55); rd(0, 0); tick(); idle();
    chk("a_mcycle", 64'(rdata), 4);
    rdy = 1;
    repeat (4) tick();
    chk("a_qsize", q.size(), 2);
    if (q.size() == 2) begin
      chk("a_q0", 64'(q[0]), {2'd0, 8'h41});
      chk("a_q1", 64'(q[1]), {2'd0, 8'h42});
    end

    // four cores in one cycle, then an overflowing write from core 3
    do_reset();
    rdy = 1; q.delete();
    for (int i = 0; i < 4; i++) mw(i, 32'h10 + i);
    tick(); idle();
    mw(3, 32'h99); tick(); idle();
    chk("b_ovf", 64'(ovf), 64'h8);
    chk("b_byte0", {cv, cc, cd}, {1'b1, 2'd0, 8'h10});
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("b_byte%0d", i), {cv, cc, cd}, {1'b1, 2'(i), 8'(8'h10 + i)});
    end
    tick();
    chk("b_idle", 64'(cv), 0);
    chk("b_qsize", q.size(), 4);
    if (q.size() == 4) chk("b_q3", 64'(q[3]), {2'd3, 8'h13});

    // clear wins over same-cycle event and halt
    en = 1; evt = 16'h0100; tick();
    clr = 1; evt = 16'h0100; mw(1, FC); tick(); idle();
    en = 0;
    chk("e_state", {ovf, halted, fini}, 0);
    rd(9, 0); tick(); idle();
    chk("e_cnt", 64'(rdata), 0);
    rd(0, 0); tick(); idle();
    chk("e_mcycle", 64'(rdata), 0);
    rdy = 0; mw(0, 32'h77); tick(); idle(); tick();
    chk("e_pending", {cv, cd}, {1'b1, 8'h77});

    // all-cores finish mode on the second instance
    do_reset();
    mw(0, FC); mw(1, FC); mw(2, FC); tick(); idle();
    en = 1; evt = 16'h1000; repeat (3) tick();
    en = 0; idle(); rd(13, 0); tick(); idle();
    chk("c_cnt3", 64'(b_rdata), 3);
    chk("c_halted", 64'(b_halted), 64'h7);
    chk("c_fini0", 64'(b_fini), 0);
    en = 1; evt = 16'h1000; mw(3, FC); tick(); idle();
    chk("c_halted_all", 64'(b_halted), 64'hf);
    chk("c_fini_n1", 64'(b_fini), 0);
    evt = 16'h1000; tick();
    chk("c_fini_n2", 64'(b_fini), 1);
    evt = 16'h1000; repeat (2) tick();
    en = 0; idle(); rd(0, 0); tick(); idle();
    chk("c_mcycle", 64'(b_rdata), 5);
    rd(13, 0); tick(); idle();
    chk("c_cnt_frozen", 64'(b_rdata), 4);

    // 32-bit carry into the high word, shadow behaviour on out-of-range select
    do_reset();
    begin
      logic [1023:0] pv;
      pv = '0;
      pv[9*64 +: 64] = 64'hffff_ffff;
      force dut.r_cnt = pv;
      #1;
      release dut.r_cnt;
      m_cnt[9] = 64'hffff_ffff;
    end
    en = 1; evt = 16'h0200; tick(); idle(); en = 0;
    rd(10, 0); tick(); idle();
    chk("d_lo", 64'(rdata), 0);
    rd(10, 1); tick(); idle();
    chk("d_hi", 64'(rdata), 1);
    rd(20, 0); tick(); idle();
    chk("d_oor", 64'(rdata), 0);
    rd(10, 1); tick(); idle();
    chk("d_shadow_kept", 64'(rdata), 1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en = $urandom_range(0, 9) != 0;
      evt = 16'($urandom);
      stall = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        wv[i] = $urandom_range(0, 3) == 0;
        addr[i*32 +: 32] = {1'($urandom_range(0, 1)), 31'($urandom)};
        wdata[i*32 +: 32] = $urandom_range(0, 149) == 0 ? FC : 32'($urandom);
      end
      clr = $urandom_range(0, 59) == 0;
      rd_en = $urandom_range(0, 1) == 1;
      rd_addr = 6'($urandom);
      rdy = $urandom_range(0, 1) == 1;
      tick();
      idle();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
